gf256_inv_seq: RTL and testbench
================================

# gf256_inv_seq

Iterative GF(2^8) multiplicative-inverse sequencer for the composite-field S-box path. It computes the inverse of a byte given in composite basis GF((2^4)^2), with field polynomial x^2 + x + v (v = 4'b1101) over GF(2^4) mod x^4 + x + 1. A small FSM shares a single GF(2^4) multiplier across the three products of the inversion, trading latency for area. It sits between the input isomorphic map and the output inverse-map/affine stage; both neighbours handle basis conversion.

## Interface
- CNT_W, 16, width of the completed-operation counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand offered
- in_ready  out  1  block can accept an operand (high only in IDLE)
- in_data  in  8  operand a = {ah[7:4], al[3:0]}, composite basis
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  8  a^-1 = {ph, pl}, composite basis; 0x00 maps to 0x00
- busy  out  1  high in every state except IDLE
- ops_done  out  CNT_W  count of completed output handshakes, wraps modulo 2^CNT_W

## Operation
- Datapath: one shared GF(2^4) multiplier (mod x^4+x+1), one square-times-v unit, one GF(2^4) squarer, one GF(2^4) inverse (inv(0) = 0).
- Math: d = v*ah^2 ^ ah*al ^ al^2; dinv = inv(d); ph = ah*dinv; pl = (ah^al)*dinv.
- FSM states and transitions:
  - IDLE: in_ready = 1. On in_valid, register ah/al and go to S_D.
  - S_D: multiplier operands = (ah, al). Register d = sqmulv(ah) ^ prod ^ sq(al). Go to S_INV.
  - S_INV: register dinv = inv(d). Go to S_H.
  - S_H: multiplier operands = (ah, dinv). Register ph. Go to S_L.
  - S_L: multiplier operands = (ah^al, dinv). Register pl. Go to S_OUT.
  - S_OUT: out_valid = 1 and out_data = {ph, pl}. On out_ready, increment ops_done and go to IDLE. Otherwise hold, with out_data stable.
- The multiplier operand mux is driven only by FSM state. Its inputs are don't-care in IDLE and S_OUT.
- in_data is ignored outside IDLE. An operand is not re-sampled while busy.
- Reset (any state, asynchronous):
  - FSM goes to IDLE.
  - in_ready = 1, out_valid = 0, busy = 0, out_data = 0x00, ops_done = 0.
  - Internal d/dinv/ph/pl registers clear to 0.
  - An in-flight operation is discarded, with no output and no count.

## Timing
- Accept edge E0 is the rising edge with in_ready & in_valid.
  - d registers at E1, dinv at E2, ph at E3, pl at E4.
  - out_valid is high from E4 onward.
- Latency: accept edge to out_valid = 4 edges.
- The output handshake completes at the first edge with out_valid & out_ready, at E4+1 at the earliest. ops_done updates on that same edge.
- in_ready rises the cycle after the output handshake. There is no overlap of consecutive operands.
- Maximum throughput is one byte per 6 cycles.
- out_ready held low stalls indefinitely in S_OUT. There is no timeout and no data change.
- ops_done wraps from 2^CNT_W-1 to 0 silently.

## Test plan
- Reset, then 0x01 -> out_data 0x01 after 4 edges; 0x02 -> 0x09; ops_done = 2.
- 0x10 -> 0x44 (d = 0xD, dinv = 0x4); 0x11 -> 0x40; 0x00 -> 0x00.
- Exhaustive sweep of all 256 operands against a composite-field reference model. For each nonzero a, a * a^-1 = 0x01 in composite arithmetic.
- Backpressure:
  - Hold out_ready low 10 cycles in S_OUT; out_data and out_valid must stay stable.
  - While stalled, in_valid = 1 with a new value must not be accepted (in_ready = 0).
- Assert rst_n low in S_H with operand 0x10: all outputs go to reset values immediately; no result is produced; ops_done = 0. Next operand 0x02 -> 0x09.
- Set CNT_W = 4 and run 17 operations: ops_done reads 1 after the last handshake.

Source files
------------

// File: rtl/gf256_inv_seq.sv
// gf256_inv_seq
// Iterative GF(2^8) multiplicative inverse in composite basis GF((2^4)^2).
// The field polynomial is x^2 + x + v with v = 4'hD, over GF(2^4) mod x^4 + x + 1.
// For a = {ah, al}:
//   d = v*ah^2 ^ ah*al ^ al^2,  dinv = inv(d),  ph = ah*dinv,  pl = (ah^al)*dinv
// A single GF(2^4) multiplier is time-shared across the three products.
// As a result the block uses 4 cycles from accept to result and has no operand overlap.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   in_data[7:0]        operand {ah, al}
//   out_valid/out_ready result handshake; the result holds while stalled
//   out_data[7:0]       inverse {ph, pl}; 0x00 maps to 0x00
//   busy                high whenever the FSM is not IDLE
//   ops_done[CNT_W-1:0] completed output handshakes, wraps silently
module gf256_inv_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_D    = 3'd1,
        ST_INV  = 3'd2,
        ST_H    = 3'd3,
        ST_L    = 3'd4,
        ST_OUT  = 3'd5
    } state_t;

    // GF(2^4) product mod x^4 + x + 1 (shift-and-add)
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end else begin
                acc = acc;
            end
            // multiply by x, folding x^4 back as x + 1
            sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
        end
        return acc;
    endfunction

    // GF(2^4) square: linear in GF(2), so a fixed XOR network suffices
    function automatic logic [3:0] gf16_sq(input logic [3:0] a);
        return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
    endfunction

    // v * a^2 with constant v = 4'hD
    function automatic logic [3:0] gf16_sqmulv(input logic [3:0] a);
        return gf16_mul(gf16_sq(a), 4'hD);
    endfunction

    // GF(2^4) inverse as a lookup; zero maps to zero
    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [3:0] r;
        case (a)
            4'h0:    r = 4'h0;
            4'h1:    r = 4'h1;
            4'h2:    r = 4'h9;
            4'h3:    r = 4'hE;
            4'h4:    r = 4'hD;
            4'h5:    r = 4'hB;
            4'h6:    r = 4'h7;
            4'h7:    r = 4'h6;
            4'h8:    r = 4'hF;
            4'h9:    r = 4'h2;
            4'hA:    r = 4'hC;
            4'hB:    r = 4'h5;
            4'hC:    r = 4'hA;
            4'hD:    r = 4'h4;
            4'hE:    r = 4'h3;
            4'hF:    r = 4'h8;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       ah_q, ah_d;
    logic [3:0]       al_q, al_d;
    logic [3:0]       d_q, d_d;
    logic [3:0]       dinv_q, dinv_d;
    logic [3:0]       ph_q, ph_d;
    logic [3:0]       pl_q, pl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       mul_a_s;
    logic [3:0]       mul_b_s;
    logic [3:0]       prod_s;

    logic             in_ready_s;
    logic             out_valid_s;
    logic             busy_s;
    logic [7:0]       out_data_s;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ah_q    <= 4'h0;
            al_q    <= 4'h0;
            d_q     <= 4'h0;
            dinv_q  <= 4'h0;
            ph_q    <= 4'h0;
            pl_q    <= 4'h0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            ah_q    <= ah_d;
            al_q    <= al_d;
            d_q     <= d_d;
            dinv_q  <= dinv_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_D;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_D:   state_d = ST_INV;
            ST_INV: state_d = ST_H;
            ST_H:   state_d = ST_L;
            ST_L:   state_d = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shared multiplier operand select, driven only by the current state
    always_comb begin
        mul_a_s = 4'h0;
        mul_b_s = 4'h0;
        case (state_q)
            ST_D: begin
                mul_a_s = ah_q;
                mul_b_s = al_q;
            end
            ST_H: begin
                mul_a_s = ah_q;
                mul_b_s = dinv_q;
            end
            ST_L: begin
                mul_a_s = ah_q ^ al_q;
                mul_b_s = dinv_q;
            end
            default: begin
                mul_a_s = 4'h0;
                mul_b_s = 4'h0;
            end
        endcase
    end

    assign prod_s = gf16_mul(mul_a_s, mul_b_s);

    // Datapath register updates, one per sequencing step
    always_comb begin
        ah_d   = ah_q;
        al_d   = al_q;
        d_d    = d_q;
        dinv_d = dinv_q;
        ph_d   = ph_q;
        pl_d   = pl_q;
        cnt_d  = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ah_d = in_data[7:4];
                    al_d = in_data[3:0];
                end else begin
                    ah_d = ah_q;
                    al_d = al_q;
                end
            end
            ST_D:   d_d    = gf16_sqmulv(ah_q) ^ prod_s ^ gf16_sq(al_q);
            ST_INV: dinv_d = gf16_inv(d_q);
            ST_H:   ph_d   = prod_s;
            ST_L:   pl_d   = prod_s;
            ST_OUT: begin
                if (out_ready) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Output decode from the state register
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b1;
        out_data_s  = 8'h00;
        case (state_q)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            ST_OUT: begin
                out_valid_s = 1'b1;
                out_data_s  = {ph_q, pl_q};
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
                busy_s      = 1'b1;
                out_data_s  = 8'h00;
            end
        endcase
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign busy      = busy_s;
    assign out_data  = out_data_s;
    assign ops_done  = cnt_q;

endmodule

// File: tb/tb_gf256_inv_seq.sv
// Self-checking bench for gf256_inv_seq.
// The reference inverse is found by brute-force search.
// It uses composite-field multiplication with x^2 = x + v, v = 4'hD.
module tb_gf256_inv_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        in_ready, out_valid, busy;
    logic [7:0]  out_data;
    logic [15:0] ops_done;
    logic        in_ready4, out_valid4, busy4;
    logic [7:0]  out_data4;
    logic [3:0]  ops_done4;

    int checks = 0;
    int errors = 0;
    int exp_ops = 0;

    gf256_inv_seq #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .ops_done(ops_done)
    );

    gf256_inv_seq #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .busy(busy4), .ops_done(ops_done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^4) multiply, polynomial arithmetic mod x^4 + x + 1
    function automatic logic [3:0] m16(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] s;
        p = 4'h0;
        s = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ s;
            s = s[3] ? ({s[2:0], 1'b0} ^ 4'h3) : {s[2:0], 1'b0};
        end
        return p;
    endfunction

    // (ah x + al)(bh x + bl) with x^2 = x + v
    function automatic logic [7:0] cmul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh;
        logic [3:0] hi;
        logic [3:0] lo;
        hh = m16(a[7:4], b[7:4]);
        hi = hh ^ m16(a[7:4], b[3:0]) ^ m16(a[3:0], b[7:4]);
        lo = m16(hh, 4'hD) ^ m16(a[3:0], b[3:0]);
        return {hi, lo};
    endfunction

    function automatic logic [7:0] ref_inv(input logic [7:0] a);
        logic [7:0] b;
        if (a == 8'h00) return 8'h00;
        for (int i = 1; i < 256; i++) begin
            b = 8'(i);
            if (cmul(a, b) == 8'h01) return b;
        end
        return 8'h00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction; inputs change and outputs are sampled at negedges
    task automatic do_op(input logic [7:0] a, input logic [7:0] exp, input int stall);
        int lat;
        logic [7:0] b;
        in_data  = a;
        in_valid = 1'b1;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        check("busy_run", {31'd0, busy}, 32'd1);
        check("in_ready_run", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd4);
        check("out_data", {24'd0, out_data}, {24'd0, exp});
        check("out_data_cnt4", {24'd0, out_data4}, {24'd0, exp});
        if (a != 8'h00) begin
            b = cmul(a, out_data);
            check("a_times_inv", {24'd0, b}, 32'd1);
        end
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_data  = ~a;
            @(negedge clk);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data", {24'd0, out_data}, {24'd0, exp});
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_ops++;
        check("post_valid", {31'd0, out_valid}, 32'd0);
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
        check("ops_done", {16'd0, ops_done}, {16'd0, 16'(exp_ops)});
        check("ops_done4", {28'd0, ops_done4}, {28'd0, 4'(exp_ops)});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
        check({tag, "_ops_done"}, {16'd0, ops_done}, 32'd0);
        check({tag, "_ops_done4"}, {28'd0, ops_done4}, 32'd0);
    endtask

    initial begin
        logic [7:0] a;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values
        do_op(8'h01, 8'h01, 0);
        do_op(8'h02, 8'h09, 0);
        check("ops_after_two", {16'd0, ops_done}, 32'd2);
        do_op(8'h10, 8'h44, 0);
        do_op(8'h11, 8'h40, 0);
        do_op(8'h00, 8'h00, 1);

        // Backpressure: 10 stalled cycles with a competing operand offered
        do_op(8'hA7, ref_inv(8'hA7), 10);

        // Exhaustive sweep with random stalls and idle gaps
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(a, ref_inv(a), int'($urandom_range(0, 2)));
        end

        // Reset while the 0x10 operation is in its ph step
        in_data  = 8'h10;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_ops = 0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_result_after_rst", {31'd0, out_valid}, 32'd0);
            check("no_count_after_rst", {16'd0, ops_done}, 32'd0);
        end
        do_op(8'h02, 8'h09, 0);

        // Counter wrap: 17 operations after a fresh reset
        rst_n = 1'b0;
        exp_ops = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            a = 8'($urandom);
            do_op(a, ref_inv(a), 0);
        end
        check("wrap_cnt4", {28'd0, ops_done4}, 32'd1);
        check("wrap_cnt16", {16'd0, ops_done}, 32'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
